button_conditioner: RTL



---
 rtl/button_pkg.sv | 28 ++
 rtl/button_conditioner_synchronizer.sv | 32 +++
 rtl/button_conditioner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_pkg
//  Description : Shared constants and width helper for the button conditioner
//  Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    localparam int BTN_SAMPLE_CNT_MAX     = 62500;
    localparam int BTN_PULSE_CNT_MAX      = 200;
    localparam int BTN_REPEAT_CNT_MAX     = 250;

    // Reduced values that keep simulation runs short
    localparam int BTN_SIM_SAMPLE_CNT_MAX = 4;
    localparam int BTN_SIM_PULSE_CNT_MAX  = 3;
    localparam int BTN_SIM_REPEAT_CNT_MAX = 2;

    // Counter width for a counter holding 0..max_val-1, never narrower than 1 bit
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

    localparam int BTN_SAMPLE_W = cnt_width(BTN_SAMPLE_CNT_MAX);
    localparam int BTN_PULSE_W  = cnt_width(BTN_PULSE_CNT_MAX + 1);
    localparam int BTN_REPEAT_W = cnt_width(BTN_REPEAT_CNT_MAX);

endpackage
`default_nettype wire

// File: rtl/button_conditioner_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : synchronizer
//  Description : Two-flop synchronizer for asynchronous level inputs
//  Revision    : 1.0 - initial release
// ============================================================================
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Synchronize, debounce and edge-detect raw button levels into
//                single-cycle press pulses. Define
//                BUTTON_CONDITIONER_AUTOREPEAT_EN to add held-button repeats.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = BTN_SAMPLE_CNT_MAX,
    parameter int PULSE_CNT_MAX  = BTN_PULSE_CNT_MAX,
    parameter int REPEAT_CNT_MAX = BTN_REPEAT_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    localparam int SAMPLE_W = cnt_width(SAMPLE_CNT_MAX);
    localparam int PULSE_W  = cnt_width(PULSE_CNT_MAX + 1);

    localparam logic [SAMPLE_W-1:0] C_SAMPLE_LAST = SAMPLE_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [PULSE_W-1:0]  C_PULSE_MAX   = PULSE_W'(PULSE_CNT_MAX);

    logic [WIDTH-1:0]    w_synced;
    logic [SAMPLE_W-1:0] r_sample_cnt;
    logic [SAMPLE_W-1:0] w_sample_cnt_next;
    logic                w_tick;

    synchronizer #(
        .WIDTH   (WIDTH)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (in),
        .o_sync  (w_synced)
    );

    // Shared sample timebase for all channels
    always_comb begin
        w_tick            = (r_sample_cnt == C_SAMPLE_LAST);
        w_sample_cnt_next = w_tick ? '0 : r_sample_cnt + SAMPLE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) r_sample_cnt <= '0;
        else     r_sample_cnt <= w_sample_cnt_next;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [PULSE_W-1:0] r_sat_cnt;
        logic [PULSE_W-1:0] w_sat_cnt_next;
        logic               w_debounced;
        logic               r_deb;
        logic               w_edge;

        // A single low synchronized sample restarts qualification
        always_comb begin
            w_sat_cnt_next = r_sat_cnt;
            if (!w_synced[i])
                w_sat_cnt_next = '0;
            else if (w_tick && (r_sat_cnt != C_PULSE_MAX))
                w_sat_cnt_next = r_sat_cnt + PULSE_W'(1);
        end

        assign w_debounced = (r_sat_cnt == C_PULSE_MAX);
        assign w_edge      = w_debounced & ~r_deb;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sat_cnt <= '0;
                r_deb     <= 1'b0;
            end else begin
                r_sat_cnt <= w_sat_cnt_next;
                r_deb     <= w_debounced;
            end
        end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        localparam int REPEAT_W = cnt_width(REPEAT_CNT_MAX);
        localparam logic [REPEAT_W-1:0] C_REPEAT_LAST = REPEAT_W'(REPEAT_CNT_MAX - 1);

        logic [REPEAT_W-1:0] r_rep_cnt;
        logic [REPEAT_W-1:0] w_rep_cnt_next;
        logic                r_rep_pulse;
        logic                w_rep_pulse_next;

        // Gating on the synchronized level stops repeats as soon as release is seen
        always_comb begin
            w_rep_cnt_next   = r_rep_cnt;
            w_rep_pulse_next = 1'b0;
            if (!w_debounced) begin
                w_rep_cnt_next = '0;
            end else if (w_tick) begin
                if (r_rep_cnt == C_REPEAT_LAST) begin
                    w_rep_cnt_next   = '0;
                    w_rep_pulse_next = w_synced[i];
                end else begin
                    w_rep_cnt_next = r_rep_cnt + REPEAT_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rep_cnt   <= '0;
                r_rep_pulse <= 1'b0;
            end else begin
                r_rep_cnt   <= w_rep_cnt_next;
                r_rep_pulse <= w_rep_pulse_next;
            end
        end

        assign out[i] = w_edge | r_rep_pulse;
`else
        assign out[i] = w_edge;
`endif
    end

endmodule
`default_nettype wire
